// File: rtl/fc_layer_ctrl.sv
// Sequencer for a bank of fully-connected neurons: streams activations in,
// steps the shared weight address, then pulses the bias add and offers the result.
module fc_layer_ctrl #(
    parameter int WORD_SIZE             = 16,
    parameter int PREVIOUS_LAYER_HEIGHT = 4,
    parameter int RAM_ADDRESS_BITS      = $clog2(PREVIOUS_LAYER_HEIGHT + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic signed [WORD_SIZE-1:0]       data_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic signed [WORD_SIZE-1:0]       data_o,
    output logic        [RAM_ADDRESS_BITS-1:0] w_addr_o,
    output logic                              sum_en_o,
    output logic                              add_bias_o,
    output logic                              valid_o,
    input  logic                              ready_i
);

    localparam logic [2:0] ACCUM     = 3'd0;
    localparam logic [2:0] BIAS_ADDR = 3'd1;
    localparam logic [2:0] BIAS_ADD  = 3'd2;
    localparam logic [2:0] SETTLE    = 3'd3;
    localparam logic [2:0] OUT       = 3'd4;

    localparam logic [RAM_ADDRESS_BITS-1:0] LAST_IDX = RAM_ADDRESS_BITS'(PREVIOUS_LAYER_HEIGHT - 1);
    localparam logic [RAM_ADDRESS_BITS-1:0] BIAS_IDX = RAM_ADDRESS_BITS'(PREVIOUS_LAYER_HEIGHT);

    logic [2:0]                  state;
    logic [RAM_ADDRESS_BITS-1:0] count;

    // Handshake flags are gated by reset so nothing is offered while held in reset.
    assign ready_o  = reset_i && (state == ACCUM);
    assign valid_o  = reset_i && (state == OUT);
    assign w_addr_o = (state == ACCUM) ? count : BIAS_IDX;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state      <= ACCUM;
            count      <= '0;
            data_o     <= '0;
            sum_en_o   <= 1'b0;
            add_bias_o <= 1'b0;
        end else begin
            sum_en_o   <= 1'b0;
            add_bias_o <= 1'b0;
            case (state)
                ACCUM: begin
                    // Address goes out this cycle; data and sum_en land with the ROM word next cycle.
                    if (valid_i) begin
                        data_o   <= data_i;
                        sum_en_o <= 1'b1;
                        count    <= count + 1'b1;
                        if (count == LAST_IDX) state <= BIAS_ADDR;
                    end
                end
                BIAS_ADDR: begin
                    add_bias_o <= 1'b1;
                    state      <= BIAS_ADD;
                end
                BIAS_ADD: state <= SETTLE;
                SETTLE:   state <= OUT;
                OUT: begin
                    if (ready_i) begin
                        count <= '0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Randomized bench for fc_layer_ctrl at H=4 and H=1, checked against a
// timestamp-based model of accepted words and output handshakes.
module tb_fc_layer_ctrl;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i, valid_i, ready_i;
    logic [W-1:0]  data_i;

    logic          rdy4, vld4, sum4, bias4;
    logic [W-1:0]  dout4;
    logic [2:0]    addr4;
    logic          rdy1, vld1, sum1, bias1;
    logic [W-1:0]  dout1;
    logic [0:0]    addr1;

    fc_layer_ctrl #(.WORD_SIZE(W), .PREVIOUS_LAYER_HEIGHT(4)) dut4 (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(rdy4), .data_o(dout4), .w_addr_o(addr4), .sum_en_o(sum4),
        .add_bias_o(bias4), .valid_o(vld4), .ready_i(ready_i));

    fc_layer_ctrl #(.WORD_SIZE(W), .PREVIOUS_LAYER_HEIGHT(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(rdy1), .data_o(dout1), .w_addr_o(addr1), .sum_en_o(sum1),
        .add_bias_o(bias1), .valid_o(vld1), .ready_i(ready_i));

    // Model: words accepted so far, cycle of last accepted word, previous-cycle handshake.
    int          hh[2] = '{4, 1};
    int          n_in[2];
    int          t_last[2];
    bit          prev_hs[2];
    logic [W-1:0] last_w[2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle(input bit vld, input bit rdy, input bit rst, input logic [W-1:0] d);
        @(negedge clk);
        reset_i = !rst;
        valid_i = vld;
        ready_i = rdy;
        data_i  = d;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit   e_rdy, e_vld, e_bias, hs;
            int   e_addr;
            logic g_rdy, g_vld, g_sum, g_bias;
            logic [W-1:0] g_dat;
            logic [31:0]  g_addr;
            e_rdy  = reset_i && (n_in[k] < hh[k]);
            e_vld  = reset_i && (n_in[k] == hh[k]) && (cyc >= t_last[k] + 4);
            e_bias = (n_in[k] == hh[k]) && (cyc == t_last[k] + 2);
            e_addr = (n_in[k] < hh[k]) ? n_in[k] : hh[k];
            if (k == 0) begin
                g_rdy = rdy4; g_vld = vld4; g_sum = sum4; g_bias = bias4; g_dat = dout4; g_addr = 32'(addr4);
            end else begin
                g_rdy = rdy1; g_vld = vld1; g_sum = sum1; g_bias = bias1; g_dat = dout1; g_addr = 32'(addr1);
            end
            if (chk_en) begin
                chk(k == 0 ? "h4_ready"  : "h1_ready",  32'(g_rdy),  32'(e_rdy));
                chk(k == 0 ? "h4_valid"  : "h1_valid",  32'(g_vld),  32'(e_vld));
                chk(k == 0 ? "h4_sum_en" : "h1_sum_en", 32'(g_sum),  32'(prev_hs[k]));
                chk(k == 0 ? "h4_bias"   : "h1_bias",   32'(g_bias), 32'(e_bias));
                chk(k == 0 ? "h4_addr"   : "h1_addr",   g_addr,      32'(e_addr));
                chk(k == 0 ? "h4_data"   : "h1_data",   32'(g_dat),  32'(last_w[k]));
            end
            if (!reset_i) begin
                n_in[k]    = 0;
                prev_hs[k] = 1'b0;
                last_w[k]  = '0;
                t_last[k]  = -100;
            end else begin
                hs = e_rdy && valid_i;
                prev_hs[k] = hs;
                if (hs) begin
                    last_w[k] = data_i;
                    n_in[k]++;
                    t_last[k] = cyc;
                end
                if (e_vld && ready_i) n_in[k] = 0;
            end
        end
        cyc++;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            n_in[k] = 0; t_last[k] = -100; prev_hs[k] = 1'b0; last_w[k] = '0;
        end
        reset_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        cycle(0, 0, 1, '0);
        cycle(0, 0, 1, '0);
        chk_en = 1'b1;
        cycle(1, 1, 1, 16'd99);                        // reset state, inputs ignored
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, W'(10 * (i + 1)));
        for (int i = 0; i < 24; i++) cycle(i % 2 == 0, 1, 0, W'($urandom));
        for (int i = 0; i < 18; i++) cycle(1, i > 14, 0, W'($urandom));
        cycle(1, 1, 0, 16'd10);
        cycle(1, 1, 0, 16'd20);
        cycle(1, 1, 1, 16'd30);                        // abandon mid-inference
        cycle(1, 1, 0, 16'hFFF9);                      // -7
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, W'($urandom));
        for (int i = 0; i < 3000; i++)
            cycle($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 64 == 0, W'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
